// File: rtl/pingpong_buffer_if.sv
// Handshake bundle between a producer/consumer pair and the ping-pong buffer.
// The master side drives writes and consumes the head; the slave is the buffer.
interface pingpong_buffer_if #(
    parameter int DATAWIDTH = 8
);
    logic [DATAWIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic                 sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           count;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, a, b, sel, out_valid, count
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, a, b, sel, out_valid, count
    );
endinterface

// File: rtl/pingpong_buffer.sv
// Two-entry ping-pong buffer feeding a 2:1 mux: banks alternate on write,
// sel points at the oldest unread bank. All outputs decode registered state.
module pingpong_buffer #(
    parameter int DATAWIDTH = 8
) (
    input logic              Clk,
    input logic              Rst,
    pingpong_buffer_if.slave bus
);
    logic [DATAWIDTH-1:0] bank_a;
    logic [DATAWIDTH-1:0] bank_b;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic                 full_a;
    logic                 full_b;
    logic                 ready;
    logic                 valid;
    logic                 push;
    logic                 pop;

    always_comb begin
        ready = wr_ptr ? ~full_b : ~full_a;
        valid = rd_ptr ? full_b : full_a;
        push  = bus.in_valid & ready;
        pop   = valid & bus.out_ready;
    end

    // A push and a pop firing together always target different banks, so the
    // set and clear terms of each full flag are mutually exclusive.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bank_a <= '0;
            bank_b <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            full_a <= 1'b0;
            full_b <= 1'b0;
        end else begin
            if (push) begin
                if (wr_ptr) bank_b <= bus.in_data;
                else        bank_a <= bus.in_data;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            full_a <= (full_a & ~(pop & ~rd_ptr)) | (push & ~wr_ptr);
            full_b <= (full_b & ~(pop &  rd_ptr)) | (push &  wr_ptr);
        end
    end

    always_comb begin
        bus.in_ready  = ready;
        bus.out_valid = valid;
        bus.sel       = rd_ptr;
        bus.a         = bank_a;
        bus.b         = bank_b;
        bus.count     = {1'b0, full_a} + {1'b0, full_b};
    end
endmodule

// File: tb/tb_pingpong_buffer.sv
// Directed bench for pingpong_buffer: a queue of accepted words predicts
// occupancy, head data and read-pointer position every cycle.
module tb_pingpong_buffer;
    logic Clk;
    logic Rst;
    int   n_cmp;
    int   n_err;
    int   pops;
    logic [7:0] q[$];

    pingpong_buffer_if #(.DATAWIDTH(8)) bus ();

    pingpong_buffer #(.DATAWIDTH(8)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check state against the scoreboard, then clock.
    task automatic cycle(input logic iv, input logic [7:0] data, input logic ordy);
        logic [7:0] head;
        logic       accept;
        bus.in_valid  = iv;
        bus.in_data   = data;
        bus.out_ready = ordy;
        #1;
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("sel", 32'(bus.sel), 32'(pops % 2));
        if (q.size() > 0) begin
            head = bus.sel ? bus.b : bus.a;
            chk("head", 32'(head), 32'(q[0]));
        end
        accept = iv && (q.size() < 2);
        if (ordy && q.size() > 0) begin
            void'(q.pop_front());
            pops++;
        end
        if (accept) q.push_back(data);
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic reset_cycle(input logic iv, input logic [7:0] data, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = data;
        bus.out_ready = ordy;
        Rst = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        q.delete();
        pops = 0;
        #1;
        chk("rst_a", 32'(bus.a), 32'h0);
        chk("rst_b", 32'(bus.b), 32'h0);
        chk("rst_sel", 32'(bus.sel), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_count", 32'(bus.count), 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        pops  = 0;
        Rst   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge Clk);

        // Reset with junk on the inputs
        reset_cycle(1'b1, 8'h5A, 1'b1);

        // Fill, then an ignored third push
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        chk("fill_a", 32'(bus.a), 32'h11);
        chk("fill_b", 32'(bus.b), 32'h22);
        cycle(1'b1, 8'h33, 1'b0);
        chk("third_a", 32'(bus.a), 32'h11);
        chk("third_b", 32'(bus.b), 32'h22);

        // Drain
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Streaming 0x01..0x08, one word per cycle
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Stall with a queued head
        cycle(1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hBB, 1'b0);
        chk("stall_b", 32'(bus.b), 32'hBB);
        chk("stall_a", 32'(bus.a), 32'hAA);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Reset while full with push and pop requested
        cycle(1'b1, 8'hC1, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0);
        chk("pre_rst_count", 32'(bus.count), 32'h2);
        reset_cycle(1'b1, 8'hC3, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
